// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - E-stage multiply/divide sequencer with fixed-latency commit to HI/LO
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   pend_hi_q, pend_lo_q;
  logic [31:0]   hi_q, lo_q;
  logic          busy_q;

  logic [31:0]   pend_hi_d, pend_lo_d;

  // Products: lower 64 bits of the extended operands give the exact signed/unsigned result.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] abs_a, abs_b, div_s, div_u;
  logic [31:0] q_mag, r_mag, q_u, r_u;
  assign a_neg  = A[31];
  assign b_neg  = B[31];
  assign b_zero = (B == 32'd0);
  assign abs_a  = a_neg ? (~A + 32'd1) : A;
  assign abs_b  = b_neg ? (~B + 32'd1) : B;
  assign div_s  = b_zero ? 32'd1 : abs_b;
  assign div_u  = b_zero ? 32'd1 : B;
  assign q_mag  = abs_a / div_s;
  assign r_mag  = abs_a % div_s;
  assign q_u    = A / div_u;
  assign r_u    = A % div_u;

  always_comb begin
    pend_hi_d = hi_q;
    pend_lo_d = lo_q;
    case (op)
      OP_MULT: begin
        pend_hi_d = prod_s[63:32];
        pend_lo_d = prod_s[31:0];
      end
      OP_MULTU: begin
        pend_hi_d = prod_u[63:32];
        pend_lo_d = prod_u[31:0];
      end
      OP_DIV: begin
        if (!b_zero) begin
          pend_lo_d = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
          pend_hi_d = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          pend_lo_d = q_u;
          pend_hi_d = r_u;
        end
      end
      default: begin
        pend_hi_d = hi_q;
        pend_lo_d = lo_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                cnt_q     <= CW'(MULT_CYCLES);
                state_q   <= RUN;
                busy_q    <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                cnt_q     <= CW'(DIV_CYCLES);
                state_q   <= RUN;
                busy_q    <= 1'b1;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed vector bench for md_sequencer
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        cancel;
  logic        Busy;
  logic [31:0] HI, LO;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[15];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  // Called in the cycle after the accept edge; returns the number of busy cycles seen.
  task automatic wait_idle(output int cyc, input logic [31:0] old_hi, input logic [31:0] old_lo);
    cyc = 0;
    while (Busy && cyc < 50) begin
      if (cyc == 0) begin
        check("hi_stable_in_run", HI, old_hi);
        check("lo_stable_in_run", LO, old_lo);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] exp_hi, exp_lo;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000064, 32'h00000000, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd4, 32'h12345678, 32'h00000000, 1'b0, 0,  32'h12345678, 32'hFFFFFFFD};
    vecs[5]  = '{3'd5, 32'h0000DEAD, 32'h00000000, 1'b1, 0,  32'h12345678, 32'hFFFFFFFD};
    vecs[6]  = '{3'd5, 32'hCAFEF00D, 32'h00000000, 1'b0, 0,  32'h12345678, 32'hCAFEF00D};
    vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 1'b0, 10, 32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{3'd6, 32'h11111111, 32'h22222222, 1'b0, 0,  32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{3'd0, 32'h00000003, 32'h00000004, 1'b1, 0,  32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{3'd0, 32'h00010000, 32'h00010000, 1'b0, 5,  32'h00000001, 32'h00000000};
    vecs[13] = '{3'd0, 32'h80000000, 32'h00000002, 1'b0, 5,  32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 10, 32'hFFFFFFFE, 32'h00000002};

    reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_vec++;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    exp_hi = 32'd0; exp_lo = 32'd0;
    for (int i = 0; i < 15; i++) begin
      n_vec++;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cancel);
      wait_idle(cyc, exp_hi, exp_lo);
      check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      exp_hi = vecs[i].hi; exp_lo = vecs[i].lo;
    end

    // Reset during busy cycle 4 of a DIV aborts it; nothing commits afterwards.
    n_vec++;
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_busy_before_reset", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_commit_busy", {31'd0, Busy}, 32'd0);
    check("abort_no_commit_hi", HI, 32'd0);
    check("abort_no_commit_lo", LO, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 1'b0);
    wait_idle(cyc, 32'd0, 32'd0);
    check("post_abort_cycles", cyc, 32'd5);
    check("post_abort_hi", HI, 32'd0);
    check("post_abort_lo", LO, 32'd12);

    // Back-to-back: second start in the first idle cycle is accepted immediately.
    n_vec++;
    issue(3'd0, 32'd5, 32'd6, 1'b0);
    wait_idle(cyc, 32'd0, 32'd12);
    check("b2b_first_cycles", cyc, 32'd5);
    check("b2b_first_lo", LO, 32'd30);
    start = 1'b1; op = 3'd1; A = 32'd7; B = 32'd8;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", {31'd0, Busy}, 32'd1);
    wait_idle(cyc, 32'd0, 32'd30);
    check("b2b_second_cycles", cyc, 32'd5);
    check("b2b_second_hi", HI, 32'd0);
    check("b2b_second_lo", LO, 32'd56);

    // A start pulsed mid-RUN must be ignored.
    n_vec++;
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'h00000BAD;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cyc, 32'd0, 32'd56);
    check("midrun_cycles", cyc, 32'd8);
    check("midrun_hi", HI, 32'd2);
    check("midrun_lo", LO, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
